// File: rtl/divider_pkg.sv
// Shared types for the restoring divider: FSM state encoding and a width helper.
// The optional divide-by-zero shortcut is enabled with DIVIDER_DIV_ZERO_EN.
package divider_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Smallest width able to index 'value' states; never less than one bit.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/divider_cu.sv
// Control unit of the restoring divider: IDLE/CALC/DONE FSM plus the step counter.
// With DIVIDER_DIV_ZERO_EN a zero divisor skips CALC and goes straight to DONE.
module divider_cu
   import divider_pkg::*;
#(
   parameter int N = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   data_ready,
`ifdef DIVIDER_DIV_ZERO_EN
   input  logic   b_zero,
`endif
   output logic   load,
   output logic   shift,
   output logic   done,
   output state_t state
);

   localparam int CW = clog2(N);

   state_t          next_state;
   logic [CW-1:0]   counter;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         counter <= '0;
         done    <= 1'b0;
      end else begin
         state <= next_state;
         // Registered from next_state so result_ready has no input-to-output path.
         done  <= (next_state == S_DONE);
         if (load) begin
            counter <= CW'(N - 1);
         end else if (shift && (counter != '0)) begin
            counter <= counter - CW'(1);
         end
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift      = 1'b0;
      case (state)
         S_IDLE: begin
            if (data_ready) begin
               load = 1'b1;
`ifdef DIVIDER_DIV_ZERO_EN
               next_state = b_zero ? S_DONE : S_CALC;
`else
               next_state = S_CALC;
`endif
            end
         end
         S_CALC: begin
            shift = 1'b1;
            if (counter == '0) next_state = S_DONE;
         end
         S_DONE: begin
            if (!data_ready) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per clock; result = {quotient, remainder}.
// Defining DIVIDER_DIV_ZERO_EN adds the div_zero port and a one-edge zero-divisor path.
module divider
   import divider_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic           data_ready,
`ifdef DIVIDER_DIV_ZERO_EN
   output logic           div_zero,
`endif
   output logic           result_ready,
   output logic [2*N-1:0] result
);

   state_t        w_state;
   logic          load;
   logic          shift;
   logic [N-1:0]  dividend_q;
   logic [N-1:0]  divisor_q;
   logic [N-1:0]  rem_q;
   logic [N:0]    rem_shift;
   logic [N-1:0]  rem_diff;
   logic          q_bit;

   divider_cu #(.N(N)) cu (
      .clk        (clk),
      .reset      (reset),
      .data_ready (data_ready),
`ifdef DIVIDER_DIV_ZERO_EN
      .b_zero     (B == '0),
`endif
      .load       (load),
      .shift      (shift),
      .done       (result_ready),
      .state      (w_state)
   );

   // N+1-bit compare; when it succeeds the true difference is below 2^N, so N bits suffice.
   assign rem_shift = {rem_q, dividend_q[N-1]};
   assign q_bit     = rem_shift[N] | (rem_shift[N-1:0] >= divisor_q);
   assign rem_diff  = rem_shift[N-1:0] - divisor_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dividend_q <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
      end else if (load) begin
         divisor_q <= B;
`ifdef DIVIDER_DIV_ZERO_EN
         if (B == '0) begin
            dividend_q <= '1;
            rem_q      <= A;
         end else begin
            dividend_q <= A;
            rem_q      <= '0;
         end
`else
         dividend_q <= A;
         rem_q      <= '0;
`endif
      end else if (shift) begin
         dividend_q <= {dividend_q[N-2:0], q_bit};
         rem_q      <= q_bit ? rem_diff : rem_shift[N-1:0];
      end
   end

`ifdef DIVIDER_DIV_ZERO_EN
   // Flag is captured at accept and dropped on the DONE->IDLE edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_zero <= 1'b0;
      end else if (load) begin
         div_zero <= (B == '0);
      end else if (result_ready && !data_ready) begin
         div_zero <= 1'b0;
      end
   end
`endif

   assign result = {dividend_q, rem_q};

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus random operands against an arithmetic model.
// Honours DIVIDER_DIV_ZERO_EN for the div_zero port and zero-divisor latency.
module tb_divider;
   import divider_pkg::*;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           data_ready;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           result_ready;
   logic [2*N-1:0] result;
`ifdef DIVIDER_DIV_ZERO_EN
   logic           div_zero;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   divider #(.N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .A            (A),
      .B            (B),
      .data_ready   (data_ready),
`ifdef DIVIDER_DIV_ZERO_EN
      .div_zero     (div_zero),
`endif
      .result_ready (result_ready),
      .result       (result)
   );

   // Reference: plain integer division, zero divisor gives {all ones, A}.
   function automatic logic [2*N-1:0] refResult(input int a, input int b);
      logic [N-1:0] ones;
      ones = '1;
      if (b == 0) return {ones, N'(a)};
      return {N'(a / b), N'(a % b)};
   endfunction

   function automatic int refLatency(input int b);
`ifdef DIVIDER_DIV_ZERO_EN
      if (b == 0) return 0;
`endif
      return N;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issue one division, measure edges from accept to result_ready, check result.
   task automatic applyStimulus(input string tag, input int a, input int b, input bit scramble);
      int edges;
      bit got;
      @(negedge clk);
      A = N'(a);
      B = N'(b);
      data_ready = 1'b1;
      edges = 0;
      got = 1'b0;
      @(posedge clk);
      #1;
      if (result_ready) got = 1'b1;
      if (scramble) begin
         @(negedge clk);
         A = N'(1);
         B = N'(1);
      end
      while (!got && edges < 4 * N + 8) begin
         @(posedge clk);
         #1;
         edges++;
         if (result_ready) got = 1'b1;
      end
      checkOutput({tag, ".latency"}, 64'(edges), 64'(refLatency(b)));
      @(negedge clk);
      checkOutput({tag, ".ready"}, 64'(result_ready), 64'd1);
      checkOutput({tag, ".result"}, 64'(result), 64'(refResult(a, b)));
`ifdef DIVIDER_DIV_ZERO_EN
      checkOutput({tag, ".div_zero"}, 64'(div_zero), 64'(b == 0));
`endif
   endtask

   task automatic releaseRequest(input string tag);
      @(negedge clk);
      data_ready = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, ".idle"}, 64'(dut.w_state), 64'(S_IDLE));
      checkOutput({tag, ".ready_low"}, 64'(result_ready), 64'd0);
`ifdef DIVIDER_DIV_ZERO_EN
      checkOutput({tag, ".div_zero_low"}, 64'(div_zero), 64'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int a;
      int b;
      reset      = 1'b0;
      data_ready = 1'b0;
      A          = '0;
      B          = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset.state", 64'(dut.w_state), 64'(S_IDLE));
      checkOutput("reset.counter", 64'(dut.cu.counter), 64'd0);
      checkOutput("reset.ready", 64'(result_ready), 64'd0);
      checkOutput("reset.result", 64'(result), 64'd0);
`ifdef DIVIDER_DIV_ZERO_EN
      checkOutput("reset.div_zero", 64'(div_zero), 64'd0);
`endif
      reset = 1'b1;

      applyStimulus("13/3", 13, 3, 1'b0);
      releaseRequest("13/3");
      applyStimulus("15/1", 15, 1, 1'b0);
      releaseRequest("15/1");
      applyStimulus("2/7", 2, 7, 1'b0);
      releaseRequest("2/7");

      // Abort a division mid-CALC with an asynchronous reset pulse.
      @(negedge clk);
      A = N'(13);
      B = N'(3);
      data_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("abort.counter", 64'(dut.cu.counter), 64'd2);
      data_ready = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("abort.state", 64'(dut.w_state), 64'(S_IDLE));
      checkOutput("abort.ready", 64'(result_ready), 64'd0);
      checkOutput("abort.result", 64'(result), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus("9/4", 9, 4, 1'b0);
      releaseRequest("9/4");

      // Held request in DONE must not restart the block.
      applyStimulus("14/4", 14, 4, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("hold.ready", 64'(result_ready), 64'd1);
         checkOutput("hold.result", 64'(result), 64'(refResult(14, 4)));
         checkOutput("hold.state", 64'(dut.w_state), 64'(S_DONE));
      end
      releaseRequest("hold");
      applyStimulus("7/2", 7, 2, 1'b0);
      releaseRequest("7/2");

      applyStimulus("11/0", 11, 0, 1'b0);
      releaseRequest("11/0");

      applyStimulus("scramble", 13, 3, 1'b1);
      releaseRequest("scramble");

      for (int i = 0; i < 24; i++) begin
         a = int'($urandom_range(0, (1 << N) - 1));
         b = int'($urandom_range(0, (1 << N) - 1));
         applyStimulus("random", a, b, 1'b0);
         releaseRequest("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
